// File: rtl/kugelblitz_pkg.sv
// Shared types and widths for the kugelblitz byte-patch stage.
// Optional statistics are enabled by defining KUGELBLITZ_PATCH_STATS_EN.
package kugelblitz_pkg;

    localparam int unsigned LANE_W        = 6;
    localparam int unsigned RULE_OFFSET_W = 16;

    // One spare bit above the beat index so a saturated counter can never alias a real beat.
    function automatic int unsigned beat_idx_width(input int unsigned offset_width);
        return offset_width - LANE_W + 1;
    endfunction

    typedef struct packed {
        logic [RULE_OFFSET_W-1:0] offset;
        logic [7:0]               data;
        logic                     enable;
    } patch_rule_t;

endpackage

// File: rtl/kugelblitz_axis_skid.sv
// One-entry AXI-Stream skid register with a registered upstream tready.
// The payload is data/keep/last/user; outputs reset to zero.
module kugelblitz_axis_skid #(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int USER_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic [KEEP_WIDTH-1:0] s_tkeep,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic                  s_tlast,
    input  logic [USER_WIDTH-1:0] s_tuser,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic [KEEP_WIDTH-1:0] m_tkeep,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,
    output logic [USER_WIDTH-1:0] m_tuser
);

    localparam int PAYLOAD_W = DATA_WIDTH + KEEP_WIDTH + 1 + USER_WIDTH;

    logic [PAYLOAD_W-1:0] s_payload;
    logic [PAYLOAD_W-1:0] out_payload_q;
    logic [PAYLOAD_W-1:0] skid_payload_q;
    logic                 out_valid_q;
    logic                 out_valid_d;
    logic                 skid_valid_q;
    logic                 skid_valid_d;
    logic                 ready_q;
    logic                 accept;
    logic                 load_out_from_in;
    logic                 load_out_from_skid;
    logic                 load_skid;

    assign s_payload = {s_tdata, s_tkeep, s_tlast, s_tuser};
    assign {m_tdata, m_tkeep, m_tlast, m_tuser} = out_payload_q;
    assign m_tvalid  = out_valid_q;
    assign s_tready  = ready_q;
    assign accept    = s_tvalid & ready_q;

    always_comb begin
        out_valid_d        = out_valid_q;
        skid_valid_d       = skid_valid_q;
        load_out_from_in   = 1'b0;
        load_out_from_skid = 1'b0;
        load_skid          = 1'b0;
        if (skid_valid_q) begin
            if (m_tready) begin
                out_valid_d        = 1'b1;
                load_out_from_skid = 1'b1;
                skid_valid_d       = 1'b0;
            end
        end else if (!out_valid_q || m_tready) begin
            out_valid_d      = accept;
            load_out_from_in = accept;
        end else if (accept) begin
            // Output stalled while a beat was accepted: park it in the skid entry.
            skid_valid_d = 1'b1;
            load_skid    = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q    <= 1'b0;
            skid_valid_q   <= 1'b0;
            ready_q        <= 1'b0;
            out_payload_q  <= '0;
            skid_payload_q <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            ready_q      <= !skid_valid_d;
            if (load_out_from_skid) begin
                out_payload_q <= skid_payload_q;
            end else if (load_out_from_in) begin
                out_payload_q <= s_payload;
            end
            if (load_skid) begin
                skid_payload_q <= s_payload;
            end
        end
    end

endmodule

// File: rtl/kugelblitz_patch_stage.sv
// AXI-Stream byte-patch stage: overwrites one frame-relative byte per frame.
// Define KUGELBLITZ_PATCH_STATS_EN to build the patched/missed frame counters.
module kugelblitz_patch_stage #(
    parameter int DATA_WIDTH   = 512,
    parameter int KEEP_WIDTH   = DATA_WIDTH / 8,
    parameter int USER_WIDTH   = 1,
    parameter int OFFSET_WIDTH = 16,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]   s_axis_tkeep,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    s_axis_tlast,
    input  logic [USER_WIDTH-1:0]   s_axis_tuser,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]   m_axis_tkeep,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic [USER_WIDTH-1:0]   m_axis_tuser,
    input  logic [OFFSET_WIDTH-1:0] cfg_offset,
    input  logic [7:0]              cfg_data,
    input  logic                    cfg_enable,
    input  logic                    cfg_valid,
    output logic                    status_in_frame,
    output logic [CNT_WIDTH-1:0]    stat_patched,
    output logic [CNT_WIDTH-1:0]    stat_missed
);

    import kugelblitz_pkg::*;

    localparam int unsigned BEAT_W = beat_idx_width(OFFSET_WIDTH);

    patch_rule_t             cfg_rule;
    patch_rule_t             shadow_q;
    patch_rule_t             active_q;
    patch_rule_t             eff_rule;
    logic                    in_frame_q;
    logic [BEAT_W-1:0]       beat_cnt_q;
    logic                    s_ready;
    logic                    accept;
    logic                    match;
    logic [DATA_WIDTH-1:0]   patched_data;

    assign cfg_rule        = '{offset: RULE_OFFSET_W'(cfg_offset), data: cfg_data, enable: cfg_enable};
    assign s_axis_tready   = s_ready;
    assign accept          = s_axis_tvalid & s_ready;
    assign status_in_frame = in_frame_q;

    // A first beat sees the shadow directly, so single-beat frames use the rule they latch.
    assign eff_rule = in_frame_q ? active_q : shadow_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q   <= '0;
            active_q   <= '0;
            in_frame_q <= 1'b0;
            beat_cnt_q <= '0;
        end else begin
            if (cfg_valid) begin
                shadow_q <= cfg_rule;
            end
            if (accept) begin
                if (!in_frame_q) begin
                    active_q <= shadow_q;
                end
                in_frame_q <= !s_axis_tlast;
                if (s_axis_tlast) begin
                    beat_cnt_q <= '0;
                end else if (beat_cnt_q != '1) begin
                    beat_cnt_q <= beat_cnt_q + BEAT_W'(1);
                end
            end
        end
    end

    always_comb begin
        match = eff_rule.enable
             && (beat_cnt_q == BEAT_W'({1'b0, eff_rule.offset[RULE_OFFSET_W-1:LANE_W]}))
             && s_axis_tkeep[eff_rule.offset[LANE_W-1:0]];
        patched_data = s_axis_tdata;
        if (match) begin
            patched_data[{eff_rule.offset[LANE_W-1:0], 3'b000} +: 8] = eff_rule.data;
        end
    end

    kugelblitz_axis_skid #(
        .DATA_WIDTH (DATA_WIDTH),
        .KEEP_WIDTH (KEEP_WIDTH),
        .USER_WIDTH (USER_WIDTH)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .s_tdata  (patched_data),
        .s_tkeep  (s_axis_tkeep),
        .s_tvalid (s_axis_tvalid),
        .s_tready (s_ready),
        .s_tlast  (s_axis_tlast),
        .s_tuser  (s_axis_tuser),
        .m_tdata  (m_axis_tdata),
        .m_tkeep  (m_axis_tkeep),
        .m_tvalid (m_axis_tvalid),
        .m_tready (m_axis_tready),
        .m_tlast  (m_axis_tlast),
        .m_tuser  (m_axis_tuser)
    );

`ifdef KUGELBLITZ_PATCH_STATS_EN
    logic                 patched_q;
    logic [CNT_WIDTH-1:0] patched_cnt_q;
    logic [CNT_WIDTH-1:0] missed_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            patched_q     <= 1'b0;
            patched_cnt_q <= '0;
            missed_cnt_q  <= '0;
        end else if (accept) begin
            if (s_axis_tlast) begin
                patched_q <= 1'b0;
                if (patched_q || match) begin
                    if (patched_cnt_q != '1) begin
                        patched_cnt_q <= patched_cnt_q + CNT_WIDTH'(1);
                    end
                end else if (eff_rule.enable) begin
                    if (missed_cnt_q != '1) begin
                        missed_cnt_q <= missed_cnt_q + CNT_WIDTH'(1);
                    end
                end
            end else if (match) begin
                patched_q <= 1'b1;
            end
        end
    end

    assign stat_patched = patched_cnt_q;
    assign stat_missed  = missed_cnt_q;
`else
    assign stat_patched = '0;
    assign stat_missed  = '0;
`endif

endmodule

// File: tb/tb_kugelblitz_patch_stage.sv
// Self-checking bench for kugelblitz_patch_stage: vector table, directed corner cases
// and randomized backpressure traffic against a frame-level reference model.
module tb_kugelblitz_patch_stage;

    logic         qsfp0_tx_clk = 1'b0;
    logic         rst = 1'b1;
    logic [511:0] s_axis_tdata = '0;
    logic [63:0]  s_axis_tkeep = '0;
    logic         s_axis_tvalid = 1'b0;
    logic         s_axis_tready;
    logic         s_axis_tlast = 1'b0;
    logic [0:0]   s_axis_tuser = '0;
    logic [511:0] m_axis_tdata;
    logic [63:0]  m_axis_tkeep;
    logic         m_axis_tvalid;
    logic         m_axis_tready = 1'b1;
    logic         m_axis_tlast;
    logic [0:0]   m_axis_tuser;
    logic [15:0]  cfg_offset = '0;
    logic [7:0]   cfg_data = '0;
    logic         cfg_enable = 1'b0;
    logic         cfg_valid = 1'b0;
    logic         status_in_frame;
    logic [31:0]  stat_patched;
    logic [31:0]  stat_missed;

    always #2 qsfp0_tx_clk = ~qsfp0_tx_clk;

    kugelblitz_patch_stage dut (
        .clk             (qsfp0_tx_clk),
        .rst             (rst),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tkeep    (s_axis_tkeep),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tready   (s_axis_tready),
        .s_axis_tlast    (s_axis_tlast),
        .s_axis_tuser    (s_axis_tuser),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tkeep    (m_axis_tkeep),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tready   (m_axis_tready),
        .m_axis_tlast    (m_axis_tlast),
        .m_axis_tuser    (m_axis_tuser),
        .cfg_offset      (cfg_offset),
        .cfg_data        (cfg_data),
        .cfg_enable      (cfg_enable),
        .cfg_valid       (cfg_valid),
        .status_in_frame (status_in_frame),
        .stat_patched    (stat_patched),
        .stat_missed     (stat_missed)
    );

`ifdef KUGELBLITZ_PATCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct {
        logic [511:0] d;
        logic [63:0]  k;
        logic         l;
        logic         u;
    } beat_t;

    typedef struct {
        logic [15:0] off;
        logic [7:0]  data;
        logic        en;
    } mrule_t;

    typedef struct {
        logic [15:0] off;
        logic [7:0]  pdata;
        logic        en;
        int unsigned nbeats;
        logic [63:0] last_keep;
        bit          hit;
        int unsigned hbeat;
        int unsigned hlane;
    } vec_t;

    beat_t       exp_q[$];
    beat_t       cap_q[$];
    beat_t       sent_q[$];
    mrule_t      shadow_m;
    int unsigned exp_patched = 0;
    int unsigned exp_missed = 0;
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;
    bit          bp_en = 1'b0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_stats(input string tag);
        chk({tag, " stat_patched"}, stat_patched, STATS ? exp_patched : 0);
        chk({tag, " stat_missed"}, stat_missed, STATS ? exp_missed : 0);
    endtask

    // Frame-level reference: byte offset -> (beat, lane); patch only if that byte exists and is kept.
    task automatic model_frame(input beat_t beats[$], input mrule_t r);
        int unsigned bi = r.off / 64;
        int unsigned li = r.off % 64;
        bit hit = r.en && (bi < beats.size()) && beats[bi].k[li];
        for (int i = 0; i < beats.size(); i++) begin
            beat_t e = beats[i];
            if (hit && i == bi) e.d[li*8 +: 8] = r.data;
            exp_q.push_back(e);
        end
        if (hit) exp_patched++;
        else if (r.en) exp_missed++;
    endtask

    function automatic beat_t rand_beat();
        beat_t b;
        for (int i = 0; i < 16; i++) b.d[i*32 +: 32] = $urandom;
        b.k = '1;
        b.l = 1'b0;
        b.u = 1'($urandom_range(0, 1));
        return b;
    endfunction

    task automatic send_beat(input beat_t b, output bit ok);
        logic rdy;
        s_axis_tdata  = b.d;
        s_axis_tkeep  = b.k;
        s_axis_tlast  = b.l;
        s_axis_tuser  = b.u;
        s_axis_tvalid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge qsfp0_tx_clk);
            rdy = s_axis_tready;
            @(posedge qsfp0_tx_clk);
            #1;
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_beat: s_axis_tready stayed 0 for 200 cycles, required 1");
        end
    endtask

    task automatic cfg(input logic [15:0] off, input logic [7:0] d, input logic en);
        cfg_offset = off;
        cfg_data   = d;
        cfg_enable = en;
        cfg_valid  = 1'b1;
        @(posedge qsfp0_tx_clk);
        #1;
        cfg_valid  = 1'b0;
        shadow_m   = '{off, d, en};
    endtask

    task automatic send_frame(input int unsigned n, input logic [63:0] last_keep,
                              input bit cfg_first, input mrule_t nr);
        beat_t beats[$];
        bit ok;
        for (int i = 0; i < n; i++) begin
            beat_t b = rand_beat();
            if (i == n - 1) begin
                b.l = 1'b1;
                b.k = last_keep;
            end
            beats.push_back(b);
        end
        sent_q = beats;
        model_frame(beats, shadow_m);
        if (cfg_first) begin
            cfg_offset = nr.off;
            cfg_data   = nr.data;
            cfg_enable = nr.en;
            cfg_valid  = 1'b1;
        end
        for (int i = 0; i < n; i++) begin
            send_beat(beats[i], ok);
            if (i == 0 && cfg_first) begin
                cfg_valid = 1'b0;
                shadow_m  = nr;
            end
        end
        s_axis_tvalid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge qsfp0_tx_clk);
            #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s drain: %0d beats still outstanding, required 0", tag, exp_q.size());
        end
    endtask

    // Output monitor: scoreboard compare plus hold-while-stalled checks.
    initial begin
        beat_t prev;
        beat_t cur;
        beat_t e;
        bit prev_stall;
        prev_stall = 1'b0;
        forever begin
            @(negedge qsfp0_tx_clk);
            cur.d = m_axis_tdata;
            cur.k = m_axis_tkeep;
            cur.l = m_axis_tlast;
            cur.u = m_axis_tuser;
            if (!mon_en || rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall tvalid", m_axis_tvalid, 1'b1);
                    chk("stall tdata", cur.d, prev.d);
                    chk("stall side", {cur.k, cur.l, cur.u}, {prev.k, prev.l, prev.u});
                end
                if (m_axis_tvalid && m_axis_tready) begin
                    cap_q.push_back(cur);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL out_beat: unexpected beat %0h, required none", cur.d[63:0]);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out tdata", cur.d, e.d);
                        chk("out side", {cur.k, cur.l, cur.u}, {e.k, e.l, e.u});
                    end
                end
                prev_stall = m_axis_tvalid && !m_axis_tready;
                prev = cur;
            end
        end
    end

    initial begin
        forever begin
            @(posedge qsfp0_tx_clk);
            #1;
            m_axis_tready = bp_en ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t   vecs[8];
        mrule_t none;
        beat_t  fb[$];
        logic [511:0] expd;
        bit ok;

        vecs[0] = '{16'h0045, 8'hA5, 1'b1, 3, {64{1'b1}}, 1'b1, 1, 5};
        vecs[1] = '{16'd200,  8'h11, 1'b1, 2, {64{1'b1}}, 1'b0, 0, 0};
        vecs[2] = '{16'h007F, 8'h77, 1'b1, 2, 64'h0000_FFFF_FFFF_FFFF, 1'b0, 0, 0};
        vecs[3] = '{16'h0000, 8'h5A, 1'b1, 1, {64{1'b1}}, 1'b1, 0, 0};
        vecs[4] = '{16'h0045, 8'hEE, 1'b0, 3, {64{1'b1}}, 1'b0, 0, 0};
        vecs[5] = '{16'h00FF, 8'h99, 1'b1, 4, {64{1'b1}}, 1'b1, 3, 63};
        vecs[6] = '{16'h0040, 8'h12, 1'b1, 2, 64'h1, 1'b1, 1, 0};
        vecs[7] = '{16'h0041, 8'h34, 1'b1, 2, 64'h1, 1'b0, 0, 0};
        none     = '{16'h0, 8'h0, 1'b0};
        shadow_m = none;

        // Reset state
        repeat (3) @(posedge qsfp0_tx_clk);
        #1;
        chk("reset s_tready", s_axis_tready, 1'b0);
        chk("reset m_tvalid", m_axis_tvalid, 1'b0);
        chk("reset m_tdata", m_axis_tdata, '0);
        chk("reset m_side", {m_axis_tkeep, m_axis_tlast, m_axis_tuser}, '0);
        chk("reset in_frame", status_in_frame, 1'b0);
        check_stats("reset");
        rst = 1'b0;
        #1;
        chk("tready before edge", s_axis_tready, 1'b0);
        @(posedge qsfp0_tx_clk);
        #1;
        chk("tready after edge", s_axis_tready, 1'b1);
        mon_en = 1'b1;

        // Basic patch with one-cycle latency and in-frame status
        cfg(16'h0045, 8'hA5, 1'b1);
        fb.delete();
        for (int i = 0; i < 3; i++) fb.push_back(rand_beat());
        fb[2].l = 1'b1;
        model_frame(fb, shadow_m);
        send_beat(fb[0], ok);
        chk("latency tvalid", m_axis_tvalid, 1'b1);
        chk("latency tdata", m_axis_tdata, fb[0].d);
        chk("in_frame after first", status_in_frame, 1'b1);
        send_beat(fb[1], ok);
        expd = fb[1].d;
        expd[5*8 +: 8] = 8'hA5;
        chk("basic patched beat", m_axis_tdata, expd);
        send_beat(fb[2], ok);
        s_axis_tvalid = 1'b0;
        chk("in_frame after last", status_in_frame, 1'b0);
        wait_drain("basic");
        check_stats("basic");

        // Vector table
        for (int v = 0; v < 8; v++) begin
            cfg(vecs[v].off, vecs[v].pdata, vecs[v].en);
            cap_q.delete();
            send_frame(vecs[v].nbeats, vecs[v].last_keep, 1'b0, none);
            wait_drain($sformatf("vec%0d", v));
            chk($sformatf("vec%0d beats", v), cap_q.size(), vecs[v].nbeats);
            for (int i = 0; i < cap_q.size() && i < sent_q.size(); i++) begin
                expd = sent_q[i].d;
                if (vecs[v].hit && i == vecs[v].hbeat) expd[vecs[v].hlane*8 +: 8] = vecs[v].pdata;
                chk($sformatf("vec%0d beat%0d", v, i), cap_q[i].d, expd);
            end
            check_stats($sformatf("vec%0d", v));
        end

        // cfg_valid coinciding with a first beat
        cfg(16'h0010, 8'h55, 1'b1);
        cap_q.delete();
        send_frame(2, '1, 1'b1, '{16'h0010, 8'h3C, 1'b1});
        wait_drain("ruleA");
        chk("ruleA old byte", cap_q[0].d[16*8 +: 8], 8'h55);
        cap_q.delete();
        send_frame(2, '1, 1'b0, none);
        wait_drain("ruleB");
        chk("ruleB new byte", cap_q[0].d[16*8 +: 8], 8'h3C);
        check_stats("rule change");

        // Randomized back-to-back traffic under backpressure
        bp_en = 1'b1;
        for (int f = 0; f < 20; f++) begin
            logic [63:0] lk;
            lk = {64{1'b1}};
            if (f % 4 == 0)
                cfg(16'($urandom_range(0, 319)), 8'($urandom), ($urandom_range(0, 3) != 0));
            lk = lk >> $urandom_range(0, 63);
            send_frame($urandom_range(1, 5), lk, 1'b0, none);
        end
        wait_drain("random");
        bp_en = 1'b0;
        @(posedge qsfp0_tx_clk);
        #1;
        check_stats("random");

        // Reset in the middle of a frame
        mon_en = 1'b0;
        cfg(16'h0042, 8'h81, 1'b1);
        fb.delete();
        for (int i = 0; i < 2; i++) fb.push_back(rand_beat());
        send_beat(fb[0], ok);
        send_beat(fb[1], ok);
        chk("midframe in_frame", status_in_frame, 1'b1);
        rst = 1'b1;
        s_axis_tvalid = 1'b0;
        #1;
        chk("midrst m_tvalid", m_axis_tvalid, 1'b0);
        chk("midrst in_frame", status_in_frame, 1'b0);
        chk("midrst s_tready", s_axis_tready, 1'b0);
        chk("midrst stat_patched", stat_patched, '0);
        chk("midrst stat_missed", stat_missed, '0);
        repeat (2) @(posedge qsfp0_tx_clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        cap_q.delete();
        exp_patched = 0;
        exp_missed  = 0;
        shadow_m    = none;
        @(posedge qsfp0_tx_clk);
        #1;
        mon_en = 1'b1;
        send_frame(2, '1, 1'b0, none);
        wait_drain("post-reset disabled");
        check_stats("post-reset disabled");
        cfg(16'h0002, 8'hC3, 1'b1);
        cap_q.delete();
        send_frame(2, '1, 1'b0, none);
        wait_drain("post-reset");
        chk("post-reset patch", cap_q[0].d[2*8 +: 8], 8'hC3);
        check_stats("post-reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
